burst_mem: RTL and testbench

BURST_MEM -- requirements
Module: burst_mem

---
 rtl/burst_mem_pkg.sv | 22 ++
 rtl/burst_mem.sv | 79 +++++++
 tb/tb_burst_mem.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/burst_mem_pkg.sv
// Shared types, widths and the read-only data pattern for the burst memory.
package burst_mem_pkg;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned LEN_W       = 2;
    localparam int unsigned LAT_W       = 4;
    localparam int unsigned LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Contents of the fixed memory: low address byte folded with the top two address bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

endpackage

// File: rtl/burst_mem.sv
// Read-only burst memory: accepts one burst request, waits LATENCY cycles,
// then streams burst_len+1 contiguous pattern beats with rlast on the final one.
module burst_mem
    import burst_mem_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rreq,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast
);

    // Counter is loaded with LATENCY-1 so the first beat lands LATENCY edges after accept.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   len;
    logic [ADDR_W-1:0]  addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            len      <= '0;
            addr     <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
        end else begin
            rdata  <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rreq) begin
                        addr     <= raddr;
                        len      <= burst_len;
                        lat_cnt  <= LAT_LOAD;
                        beat_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                // lat_cnt is already zero in BURST, so both states share the beat path.
                WAIT, BURST: begin
                    if (lat_cnt == '0) begin
                        rvalid <= 1'b1;
                        rdata  <= pattern(addr);
                        addr   <= addr + 1'b1;
                        if (beat_cnt == len) begin
                            rlast <= 1'b1;
                            state <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= BURST;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!rreq) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem.sv
// Self-checking bench for burst_mem: table of bursts checked through a beat scoreboard,
// plus hand-written reset-abort and LATENCY=1 sequences.
module tb_burst_mem;

    localparam int LAT = 3;

    typedef struct {
        logic [9:0]  addr;
        logic [1:0]  len;
        logic [31:0] exp;
        bit          hold;
        bit          meddle;
        bit          drop;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rreq;
    logic [9:0] raddr;
    logic [1:0] burst_len;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rlast;

    logic       rreq1;
    logic [9:0] raddr1;
    logic [1:0] burst_len1;
    logic [7:0] rdata1;
    logic       rvalid1;
    logic       rlast1;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    beat_t sb[$];
    vec_t  vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    burst_mem #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .rreq(rreq), .raddr(raddr), .burst_len(burst_len),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast)
    );

    burst_mem #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .rreq(rreq1), .raddr(raddr1), .burst_len(burst_len1),
        .rdata(rdata1), .rvalid(rvalid1), .rlast(rlast1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        beat_t b;
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got rdata=0x%0h at cycle %0d, want no beat", rdata, cyc);
            end else begin
                b = sb.pop_front();
                check("beat_data", 32'(rdata), 32'(b.data));
                check("beat_last", 32'(rlast), 32'(b.last));
                check("beat_cycle", 32'(cyc), 32'(b.cyc));
            end
        end else begin
            check("idle_rdata_rlast", 32'({rdata, rlast}), 32'd0);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_beat: got no beat at cycle %0d, want rdata=0x%0h", cyc, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    task automatic push_beats(input logic [31:0] exp, input int nbeats, input int last_idx, input int start);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = exp[8*i +: 8];
            b.last = (i == last_idx);
            b.cyc  = start + i;
            sb.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d beats outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Called at negedge+1 with the DUT idle; the next rising edge accepts.
    task automatic run_burst(input vec_t v);
        int hits;
        rreq      = 1'b1;
        raddr     = v.addr;
        burst_len = v.len;
        push_beats(v.exp, int'(v.len) + 1, int'(v.len), cyc + 1 + LAT);
        if (v.meddle || v.drop) begin
            step();
            if (v.meddle) begin
                raddr     = 10'h200;
                burst_len = 2'd0;
            end
            if (v.drop) rreq = 1'b0;
        end
        wait_drain("burst");
        if (v.hold) begin
            hits = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (rvalid === 1'b1) hits++;
            end
            check("hold_no_new_beat", 32'(hits), 32'd0);
        end
        rreq = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{addr: 10'h010, len: 2'd0, exp: 32'h0000_0010, hold: 1'b0, meddle: 1'b0, drop: 1'b0};
        vecs[1] = '{addr: 10'h3FE, len: 2'd3, exp: 32'h0100_FCFD, hold: 1'b0, meddle: 1'b0, drop: 1'b0};
        vecs[2] = '{addr: 10'h0A5, len: 2'd1, exp: 32'h0000_A6A5, hold: 1'b1, meddle: 1'b0, drop: 1'b0};
        vecs[3] = '{addr: 10'h040, len: 2'd3, exp: 32'h4342_4140, hold: 1'b0, meddle: 1'b1, drop: 1'b0};
        vecs[4] = '{addr: 10'h2F0, len: 2'd2, exp: 32'h00F0_F3F2, hold: 1'b0, meddle: 1'b0, drop: 1'b1};
        vecs[5] = '{addr: 10'h1FF, len: 2'd1, exp: 32'h0000_02FE, hold: 1'b0, meddle: 1'b0, drop: 1'b0};

        reset      = 1'b1;
        rreq       = 1'b0;
        raddr      = '0;
        burst_len  = '0;
        rreq1      = 1'b0;
        raddr1     = '0;
        burst_len1 = '0;
        step();
        step();
        check("reset_outputs", 32'({rvalid, rlast, rdata}), 32'd0);
        check("reset_outputs_lat1", 32'({rvalid1, rlast1, rdata1}), 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // Reset after the second beat of a 4-beat burst aborts it.
        rreq      = 1'b1;
        raddr     = 10'h080;
        burst_len = 2'd3;
        push_beats(32'h0000_8180, 2, -1, cyc + 1 + LAT);
        wait_drain("pre_reset");
        reset = 1'b1;
        rreq  = 1'b0;
        #1;
        check("reset_mid_burst", 32'({rvalid, rlast, rdata}), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        run_burst('{addr: 10'h100, len: 2'd1, exp: 32'h0000_0001, hold: 1'b0, meddle: 1'b0, drop: 1'b0});

        // LATENCY=1 instance: first beat one edge after accept.
        rreq1      = 1'b1;
        raddr1     = 10'h005;
        burst_len1 = 2'd1;
        step();
        check("lat1_no_beat_at_accept", 32'(rvalid1), 32'd0);
        step();
        check("lat1_beat0", 32'({rvalid1, rlast1, rdata1}), 32'({1'b1, 1'b0, 8'h05}));
        step();
        check("lat1_beat1", 32'({rvalid1, rlast1, rdata1}), 32'({1'b1, 1'b1, 8'h06}));
        rreq1 = 1'b0;
        step();
        check("lat1_after_burst", 32'({rvalid1, rlast1, rdata1}), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
